mem_port_arbiter: RTL

Sequences and arbitrates the single shared instruction/data memory between the fetch stage and the MEM stage, replacing half-rate time multiplexing with a request/grant protocol. Sits between the pipeline and the Memory block, driving its read/write, address, size and sign controls. Produces stall indications so the pipeline control can freeze PC, IF_ID and later stages while an access is pending.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing one memory port between instruction fetch and data access.
// Optional fetch-starvation guard is compiled in with `define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  input  logic              dm_signed,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_signed,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_stall,
  output logic              data_stall
);

  localparam int         LAT       = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_idle;
  logic w_access;
  logic w_resp;
  logic w_fetch_first;
  logic w_if_gnt;
  logic w_dm_gnt;

  // Grants are gated by rst so nothing is accepted while reset is held.
  assign w_idle   = (r_state == S_IDLE) & ~rst;
  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);
  assign w_dm_gnt = w_idle & dm_req & ~(w_fetch_first & if_req);
  assign w_if_gnt = w_idle & if_req & ~w_dm_gnt;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 2);
  logic [SC_W-1:0] r_starve;

  assign w_fetch_first = (int'(r_starve) == STARVE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !if_req || w_if_gnt) r_starve <= '0;
    else if (w_dm_gnt)              r_starve <= r_starve + SC_W'(1);
  end
`else
  logic w_unused_starve;
  assign w_fetch_first   = 1'b0;
  assign w_unused_starve = ^STARVE_LIMIT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_IF;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dm_gnt) begin
            r_owner  <= OWN_DM;
            r_we     <= dm_we;
            r_addr   <= dm_addr;
            r_wdata  <= dm_wdata;
            r_size   <= dm_size;
            r_signed <= dm_signed;
            r_cnt    <= CNT_INIT;
            r_state  <= S_ACCESS;
          end else if (w_if_gnt) begin
            r_owner  <= OWN_IF;
            r_we     <= 1'b0;
            r_addr   <= if_addr;
            r_wdata  <= '0;
            r_size   <= SIZE_WORD;
            r_signed <= 1'b0;
            r_cnt    <= CNT_INIT;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            if (r_owner == OWN_DM) r_dm_rdata <= r_we ? '0 : mem_rdata;
            else                   r_if_rdata <= mem_rdata;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_gnt     = w_if_gnt;
  assign dm_gnt     = w_dm_gnt;
  assign if_rvalid  = w_resp & (r_owner == OWN_IF);
  assign dm_rvalid  = w_resp & (r_owner == OWN_DM);
  assign if_rdata   = r_if_rdata;
  assign dm_rdata   = r_dm_rdata;

  assign mem_read   = w_access & ~r_we;
  assign mem_write  = w_access & r_we;
  assign mem_addr   = w_access ? r_addr   : '0;
  assign mem_wdata  = w_access ? r_wdata  : '0;
  assign mem_size   = w_access ? r_size   : '0;
  assign mem_signed = w_access & r_signed;

  assign fetch_stall = ~rst & ((if_req & ~w_if_gnt) |
                               ((r_state != S_IDLE) & (r_owner == OWN_IF) & ~if_rvalid));
  assign data_stall  = ~rst & ((dm_req & ~w_dm_gnt) |
                               ((r_state != S_IDLE) & (r_owner == OWN_DM) & ~dm_rvalid));

endmodule
